// File: rtl/vga_pkg.sv
// Shared constants, state encoding and pixel-entry layout
// for the VGA output stage.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int FIFO_DEPTH_DEF = 1024;

  localparam int H_TOTAL_DEF =
    H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF =
    V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // FIFO entry: {tuser, tlast, tdata}
  localparam int PIX_W    = 26;
  localparam int USER_BIT = 25;
  localparam int LAST_BIT = 24;

  typedef enum logic [1:0] {
    SEARCH,
    WAIT_FRAME,
    RUN
  } state_e;

  function automatic logic [11:0] rgb444(
    input logic [23:0] d
  );
    return {d[23:20], d[15:12], d[7:4]};
  endfunction

endpackage

// File: rtl/vga_axis_out_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty
// and a synchronous flush that wins over read and write.
module sync_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    wr_ok   = wr_en && !full_q && !flush;
    rd_ok   = rd_en && !empty_q && !flush;
    wp_d    = wp_q + AW'(wr_ok);
    rp_d    = rp_q + AW'(rd_ok);
    cnt_d   = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= wr_data;
  end

  assign rd_data = mem_q[rp_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/vga_axis_out.sv
// VGA raster generator fed from an RGB stream through a
// line FIFO; the stream is locked to the raster on SOF.
module vga_axis_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        locked,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          lock_q, lock_d;
  logic          unf_q, unf_d;

  logic             active, frame_end, pop_cyc, err;
  logic             sof_pos, eol_pos, ready;
  logic             f_wr, f_rd, f_full, f_empty;
  logic [PIX_W-1:0] f_head;

  sync_fifo_fwft #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .flush   (err),
    .wr_en   (f_wr),
    .wr_data ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .rd_en   (f_rd),
    .rd_data (f_head),
    .full    (f_full),
    .empty   (f_empty)
  );

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end

    active    = (h_q < H_ACT) && (v_q < V_ACT);
    frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    sof_pos   = (h_q == '0) && (v_q == '0);
    eol_pos   = (h_q == H_EOL);
    pop_cyc   = (state_q == RUN) && active;

    // Empty slot or misplaced tuser/tlast both break the lock
    err = pop_cyc && (f_empty ||
          (f_head[USER_BIT] != sof_pos) ||
          (f_head[LAST_BIT] != eol_pos));
    f_rd = pop_cyc && !f_empty;

    ready = en_q && ((state_q == SEARCH) || !f_full);
    f_wr  = s_axis_tvalid && ready &&
            ((state_q != SEARCH) || s_axis_tuser);

    state_d = state_q;
    unique case (state_q)
      SEARCH:
        if (s_axis_tvalid && ready && s_axis_tuser)
          state_d = WAIT_FRAME;
      WAIT_FRAME:
        if (frame_end) state_d = RUN;
      RUN:
        if (err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase

    en_d   = 1'b1;
    rgb_d  = (pop_cyc && !err) ? rgb444(f_head[23:0]) : '0;
    hs_d   = ((h_q >= HS_ON) && (h_q < HS_OFF)) ?
             SYNC_POL : ~SYNC_POL;
    vs_d   = ((v_q >= VS_ON) && (v_q < VS_OFF)) ?
             SYNC_POL : ~SYNC_POL;
    lock_d = (state_q == RUN) && !err;
    unf_d  = err;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= SEARCH;
      en_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      lock_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      en_q    <= en_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      lock_q  <= lock_d;
      unf_q   <= unf_d;
    end
  end

  assign s_axis_tready = ready;
  assign VGA_R         = rgb_q[11:8];
  assign VGA_G         = rgb_q[7:4];
  assign VGA_B         = rgb_q[3:0];
  assign vid_hsync     = hs_q;
  assign vid_vsync     = vs_q;
  assign locked        = lock_q;
  assign underflow     = unf_q;

endmodule

// File: doc/vga_axis_out.md
Name: vga_axis_out

Overview:
- Video output stage that sits directly upstream of the VGA pins (VGA_R/G/B, vid_hsync, vid_vsync).
- Consumes the 24-bit RGB AXI4-Stream from the edge-detection pipeline and buffers it in a line FIFO.
- Generates 640x480@60 VGA timing, and locks the stream to the raster on start-of-frame (tuser).
- Drives 4-bit-per-channel colour, blanked outside the active area.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FIFO_DEPTH, 1024, pixel FIFO entries; power of two, at least H_ACTIVE
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- aclk  in  1  pixel clock (25.175 MHz nominal); the only clock
- aresetn  in  1  reset; asynchronous, active-low
- s_axis_tdata  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tuser  in  1  start of frame; set on pixel (0,0)
- s_axis_tlast  in  1  end of line; set on pixel H_ACTIVE-1
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- locked  out  1  raster locked to stream
- underflow  out  1  one-cycle pulse on FIFO underflow or framing error

Behaviour:
- Reset values:
  - h_cnt = v_cnt = 0.
  - VGA_R/G/B = 0.
  - vid_hsync = vid_vsync = ~SYNC_POL.
  - locked = 0, underflow = 0, s_axis_tready = 0.
  - State SEARCH, FIFO empty.
  - Reset asserted mid-frame returns everything to these values immediately; no partial line is completed.
- Timing counters:
  - H_TOTAL = 800 and V_TOTAL = 525 at the defaults (sum of the four H parameters and the four V parameters respectively).
  - h_cnt runs free 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
  - Counters run in every state.
- Active and sync windows:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; transitions occur with h_cnt = 0.
- Output pipeline:
  - All pin outputs are registered from the same counter value, giving 1 cycle of latency from counter to pins; sync and colour stay aligned.
  - RGB = tdata[23:20], [15:12], [7:4] of the popped pixel when active && RUN; otherwise 0.
- FIFO:
  - Entries are 26 bits: {tuser, tlast, tdata}.
  - Write when tvalid && tready.
  - In WAIT_FRAME and RUN, tready = !full (full is registered).
  - Read is show-ahead; one pop per active cycle in RUN.
  - A simultaneous read and write keeps the count unchanged.
- FSM:
  - SEARCH:
    - tready = 1; beats with tuser = 0 are discarded.
    - A beat with tuser = 1 is written to the FIFO and the FSM moves to WAIT_FRAME.
  - WAIT_FRAME:
    - FIFO fills; locked = 0.
    - At h_cnt = H_TOTAL-1 && v_cnt = V_TOTAL-1, move to RUN; counters are (0,0) on the next cycle.
  - RUN:
    - locked = 1.
    - Errors:
      - Underflow: FIFO empty on an active cycle.
      - Popped pixel (0,0) has tuser = 0.
      - Any other popped pixel has tuser = 1.
      - Popped pixel at h_cnt = H_ACTIVE-1 has tlast = 0.
      - Tlast = 1 at any other position.
    - On any error:
      - underflow pulses 1 cycle.
      - That pixel and the rest of the frame are output black.
      - FIFO is flushed and the FSM returns to SEARCH; locked drops the next cycle.
      - Sync outputs continue uninterrupted.
- Boundary conditions:
  - Full FIFO: tready = 0, no overwrite.
  - Blanking intervals: no pops occur.
  - A tuser beat arriving in the same cycle as a flush is discarded; the next SOF is used.

Decomposition:
- Package vga_pkg:
  - Default timing constants.
  - Derived H_TOTAL/V_TOTAL.
  - State enum {SEARCH, WAIT_FRAME, RUN}.
  - Pixel-entry field offsets.
- One sub-module, sync_fifo_fwft:
  - Show-ahead synchronous FIFO parameterised by WIDTH/DEPTH.
  - Provides full, empty, and a synchronous flush.

Test Plan:
- Reset:
  - Stimulus: hold aresetn = 0 for 10 cycles with tvalid = 1.
  - Response: RGB = 0, hsync = vsync = 1, tready = 0, locked = 0, underflow = 0.
- Free-running timing, no stream:
  - hsync = 0 for exactly 96 cycles, starting at h_cnt 656, every 800 cycles.
  - vsync = 0 on lines 490-491, every 525 lines.
  - RGB stays 0 and locked = 0.
- Lock and display:
  - Stimulus: stream 640x480 frames with correct tuser/tlast, with pixel (x,y) = 24'hF0A050 except (5,0) = 24'h123456.
  - Response: locked rises at the frame start after SOF.
  - Displayed pixel (0,0) = R F, G A, B 5; pixel (5,0) = R 1, G 3, B 5.
- Pre-SOF garbage:
  - Stimulus: 100 beats with tuser = 0, then a frame.
  - Response: the garbage is discarded; the first displayed pixel equals the SOF beat.
- Underflow:
  - Stimulus: after lock, drop tvalid from pixel 300 of line 10 onward.
  - Response: underflow pulses once; RGB = 0 for the remainder; locked = 0; relock on the next SOF.
- Framing error and backpressure:
  - Stimulus: tlast missing on pixel 639 of line 3.
  - Response: underflow pulse and return to SEARCH.
  - Stimulus: with FIFO full (1024 entries) in WAIT_FRAME.
  - Response: tready = 0 and no data is lost.
